// File: rtl/mips_pkg.sv
// Purpose: shared types and constants for the multicycle MIPS PC/IR/memory-access slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: PC source encoding, memory-access FSM states, reset vector, alignment helper.
package mips_pkg;

   // Next-PC source selected by the control unit.
   typedef enum logic [1:0] {
      PCS_ALU    = 2'b00,   // ALUResult (PC+4 during fetch)
      PCS_ALUOUT = 2'b01,   // registered ALU output (branch target)
      PCS_JUMP   = 2'b10,   // {PC[31:28], IR[25:0], 2'b00}
      PCS_HOLD   = 2'b11    // no PC write
   } pc_src_t;

   // Memory-access sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      WAIT_RD = 2'b01,
      WAIT_WR = 2'b10
   } mem_state_t;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   // Word alignment test for instruction addresses.
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_ir_unit_pc_sel.sv
// Purpose: next-PC selection and word-alignment check.
// Latency: purely combinational.
// Backpressure: none; the write enable arrives already gated by the caller's stall.
// Ports: pc_source/pc_we select and enable; pc/ir/alu_result/alu_out are the candidate
//        sources; next_pc is the selected value, pc_load commits it, align_err flags a
//        rejected misaligned write.
module pc_sel
   import mips_pkg::*;
(
   input  logic [1:0]  pc_source,
   input  logic        pc_we,
   input  logic [31:0] pc,
   input  logic [31:0] ir,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   output logic [31:0] next_pc,
   output logic        pc_load,
   output logic        align_err
);

   pc_src_t src;
   logic    src_valid;
   logic    aligned;

   assign src = pc_src_t'(pc_source);

   always_comb begin
      next_pc = pc;
      case (src)
         PCS_ALU:    next_pc = alu_result;
         PCS_ALUOUT: next_pc = alu_out;
         PCS_JUMP:   next_pc = {pc[31:28], ir[25:0], 2'b00};
         default:    next_pc = pc;
      endcase
   end

   // HOLD is a "no write" encoding, so it can never raise an alignment error.
   assign src_valid = (src != PCS_HOLD);
   assign aligned   = is_word_aligned(next_pc);
   assign pc_load   = pc_we & src_valid & aligned;
   assign align_err = pc_we & src_valid & ~aligned;

endmodule

// File: rtl/pc_ir_unit.sv
// Purpose: PC/IR/MDR registers and wait-state memory-access sequencer of a multicycle MIPS.
// Latency: zero-wait access completes at the request edge; each mem_ready=0 cycle adds one.
// Backpressure: Stall is high while an access waits; all PC/IR/MDR updates are held off.
// Ports: Clk/Reset; control-unit strobes (PCWrite..IRWrite, PCSource); datapath inputs
//        ALUResult/ALUOut/B/Zero; memory port mem_*; architectural PC/IR/MDR; decoded
//        IR fields; Stall and the one-cycle AlignErr pulse.
module pc_ir_unit
   import mips_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCWrite,
   input  logic        PCWriteCond,
   input  logic        BranchNe,
   input  logic        IorD,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [1:0]  PCSource,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ALUOut,
   input  logic [31:0] B,
   input  logic        Zero,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] PC,
   output logic [31:0] IR,
   output logic [31:0] MDR,
   output logic [5:0]  Op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic        Stall,
   output logic        AlignErr
);

   mem_state_t  state;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_irw;

   logic        rd_req;
   logic        wr_req;
   logic        active;
   logic        rd_done;
   logic        ir_load;
   logic        pc_we;
   logic [31:0] next_pc;
   logic        pc_load;
   logic        align_err;

   // A write wins over a simultaneous read; IRWrite alone implies an instruction read.
   assign wr_req = MemWrite;
   assign rd_req = (IRWrite | MemRead) & ~MemWrite;

   // In IDLE the port follows the control inputs; in WAIT_* it replays the latched access.
   always_comb begin
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      active    = 1'b0;
      case (state)
         IDLE: begin
            mem_addr  = IorD ? ALUOut : PC;
            mem_wdata = B;
            mem_re    = rd_req;
            mem_we    = wr_req;
            active    = rd_req | wr_req;
         end
         WAIT_RD: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_re    = 1'b1;
            active    = 1'b1;
         end
         WAIT_WR: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_we    = 1'b1;
            active    = 1'b1;
         end
         default: begin
            mem_addr  = 32'h0;
         end
      endcase
   end

   assign Stall   = active & ~mem_ready;
   assign rd_done = mem_re & mem_ready;
   // IR load intent is captured with the access so a waited fetch still lands in IR.
   assign ir_load = rd_done & ((state == IDLE) ? IRWrite : lat_irw);

   assign pc_we = (PCWrite | (PCWriteCond & (Zero ^ BranchNe))) & ~Stall;

   pc_sel u_pc_sel (
      .pc_source  (PCSource),
      .pc_we      (pc_we),
      .pc         (PC),
      .ir         (IR),
      .alu_result (ALUResult),
      .alu_out    (ALUOut),
      .next_pc    (next_pc),
      .pc_load    (pc_load),
      .align_err  (align_err)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         PC        <= RESET_VECTOR;
         IR        <= 32'h0;
         MDR       <= 32'h0;
         AlignErr  <= 1'b0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         lat_irw   <= 1'b0;
      end else begin
         AlignErr <= align_err;
         if (pc_load) PC  <= next_pc;
         if (rd_done) MDR <= mem_rdata;
         if (ir_load) IR  <= mem_rdata;
         case (state)
            IDLE: begin
               if (Stall) begin
                  lat_addr  <= mem_addr;
                  lat_wdata <= mem_wdata;
                  lat_irw   <= IRWrite & ~MemWrite;
                  state     <= wr_req ? WAIT_WR : WAIT_RD;
               end
            end
            WAIT_RD, WAIT_WR: begin
               if (mem_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Op    = IR[31:26];
   assign rs    = IR[25:21];
   assign rt    = IR[20:16];
   assign rd    = IR[15:11];
   assign shamt = IR[10:6];
   assign funct = IR[5:0];
   assign imm16 = IR[15:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Purpose: self-checking bench for pc_ir_unit (vector table plus multi-cycle sequences).
// Latency: expected register values are queued at drive time and popped after the edge.
// Backpressure: memory readiness is scripted per cycle by the stimulus.
module tb_pc_ir_unit;
   import mips_pkg::*;

   logic        Clk, Reset;
   logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
   logic [1:0]  PCSource;
   logic [31:0] ALUResult, ALUOut, B;
   logic        Zero;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_re, mem_we, mem_ready;
   logic [31:0] PC, IR, MDR;
   logic [5:0]  Op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic        Stall, AlignErr;

   pc_ir_unit dut (
      .Clk(Clk), .Reset(Reset),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCSource(PCSource),
      .ALUResult(ALUResult), .ALUOut(ALUOut), .B(B), .Zero(Zero),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .PC(PC), .IR(IR), .MDR(MDR),
      .Op(Op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
      .Stall(Stall), .AlignErr(AlignErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ctl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite}
   // e_srw = expected {Stall, mem_re, mem_we} before the edge
   typedef struct {
      logic [6:0]  ctl;
      logic [1:0]  pcs;
      logic        zero;
      logic        rdy;
      logic [31:0] alur, aluo, b, rdata;
      logic [2:0]  e_srw;
      logic [31:0] e_addr, e_pc, e_ir, e_mdr;
      logic        e_aerr;
   } vec_t;

   typedef struct {
      logic [31:0] pc, ir, mdr;
      logic        aerr;
   } exp_t;

   vec_t vec [14];
   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] ctl, input logic [1:0] pcs, input logic zero,
                        input logic rdy, input logic [31:0] alur, input logic [31:0] aluo,
                        input logic [31:0] b, input logic [31:0] rdata);
      {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite} = ctl;
      PCSource  = pcs;
      Zero      = zero;
      mem_ready = rdy;
      ALUResult = alur;
      ALUOut    = aluo;
      B         = b;
      mem_rdata = rdata;
   endtask

   task automatic chk_comb(input string nm, input logic [2:0] srw,
                           input logic [31:0] addr, input logic [31:0] wdata);
      chk1({nm, " Stall"}, Stall, srw[2]);
      chk1({nm, " mem_re"}, mem_re, srw[1]);
      chk1({nm, " mem_we"}, mem_we, srw[0]);
      chk32({nm, " mem_addr"}, mem_addr, addr);
      chk32({nm, " mem_wdata"}, mem_wdata, wdata);
   endtask

   task automatic post_check(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb.pop_front();
         chk32({nm, " PC"}, PC, e.pc);
         chk32({nm, " IR"}, IR, e.ir);
         chk32({nm, " MDR"}, MDR, e.mdr);
         chk1({nm, " AlignErr"}, AlignErr, e.aerr);
         chk32({nm, " fields"}, {Op, rs, rt, rd, shamt, funct}, e.ir);
         chk32({nm, " imm16"}, {16'h0, imm16}, {16'h0, e.ir[15:0]});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //        ctl          pcs    z     rdy   alur           aluo           b              rdata          srw     addr           pc             ir             mdr            aerr
      vec[0]  = '{7'b0000000, 2'b11, 1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0};
      vec[1]  = '{7'b1000001, 2'b00, 1'b0, 1'b1, 32'h4,         32'h0,         32'h0,         32'h0000_0020, 3'b010, 32'h0,         32'h4,         32'h20,        32'h20,        1'b0};
      vec[2]  = '{7'b0100000, 2'b01, 1'b1, 1'b1, 32'h0,         32'h40,        32'h0,         32'hFFFF_FFFF, 3'b000, 32'h4,         32'h40,        32'h20,        32'h20,        1'b0};
      vec[3]  = '{7'b0110000, 2'b01, 1'b1, 1'b1, 32'h0,         32'h80,        32'h0,         32'hFFFF_FFFF, 3'b000, 32'h40,        32'h40,        32'h20,        32'h20,        1'b0};
      vec[4]  = '{7'b0110000, 2'b01, 1'b0, 1'b1, 32'h0,         32'h80,        32'h0,         32'hFFFF_FFFF, 3'b000, 32'h40,        32'h80,        32'h20,        32'h20,        1'b0};
      vec[5]  = '{7'b1000000, 2'b00, 1'b0, 1'b1, 32'h6,         32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h80,        32'h80,        32'h20,        32'h20,        1'b1};
      vec[6]  = '{7'b0000000, 2'b11, 1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h80,        32'h80,        32'h20,        32'h20,        1'b0};
      vec[7]  = '{7'b0001100, 2'b11, 1'b0, 1'b1, 32'h0,         32'h200,       32'h0,         32'h1234_5678, 3'b010, 32'h200,       32'h80,        32'h20,        32'h1234_5678, 1'b0};
      vec[8]  = '{7'b0001010, 2'b11, 1'b0, 1'b1, 32'h0,         32'h300,       32'hCAFE_F00D, 32'h5555_AAAA, 3'b001, 32'h300,       32'h80,        32'h20,        32'h1234_5678, 1'b0};
      vec[9]  = '{7'b0001110, 2'b11, 1'b0, 1'b1, 32'h0,         32'h304,       32'h0BAD_C0DE, 32'h5555_AAAA, 3'b001, 32'h304,       32'h80,        32'h20,        32'h1234_5678, 1'b0};
      vec[10] = '{7'b1000000, 2'b11, 1'b0, 1'b1, 32'h46,        32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h80,        32'h80,        32'h20,        32'h1234_5678, 1'b0};
      vec[11] = '{7'b1000001, 2'b00, 1'b0, 1'b1, 32'h84,        32'h0,         32'h0,         32'h0800_0010, 3'b010, 32'h80,        32'h84,        32'h0800_0010, 32'h0800_0010, 1'b0};
      vec[12] = '{7'b1000000, 2'b00, 1'b0, 1'b1, 32'h1000_0008, 32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h84,        32'h1000_0008, 32'h0800_0010, 32'h0800_0010, 1'b0};
      vec[13] = '{7'b1000000, 2'b10, 1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF, 3'b000, 32'h1000_0008, 32'h1000_0040, 32'h0800_0010, 32'h0800_0010, 1'b0};

      // Reset state
      Reset = 1'b1;
      drive(7'b0000000, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(negedge Clk);
      chk32("reset PC", PC, 32'h0);
      chk32("reset IR", IR, 32'h0);
      chk32("reset MDR", MDR, 32'h0);
      chk1("reset AlignErr", AlignErr, 1'b0);
      chk_comb("reset", 3'b000, 32'h0, 32'h0);
      Reset = 1'b0;

      // Vector table: fetch, branches, misalignment, loads/stores, hold, jump
      for (int i = 0; i < 14; i++) begin
         @(negedge Clk);
         drive(vec[i].ctl, vec[i].pcs, vec[i].zero, vec[i].rdy,
               vec[i].alur, vec[i].aluo, vec[i].b, vec[i].rdata);
         #1;
         chk_comb($sformatf("vec%0d", i), vec[i].e_srw, vec[i].e_addr, vec[i].b);
         sb.push_back('{vec[i].e_pc, vec[i].e_ir, vec[i].e_mdr, vec[i].e_aerr});
         @(posedge Clk);
         #1;
         post_check($sformatf("vec%0d", i));
      end

      // Fetch with 3 wait states; address inputs wiggle during the wait
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         drive(7'b1000001, 2'b00, 1'b0, (c == 3), 32'h1000_0044,
               (c == 0) ? 32'h0 : 32'h0000_BAD0, 32'h0,
               (c == 3) ? 32'h0123_4567 : (32'hAAAA_0000 + 32'(c)));
         if (c != 0) IorD = 1'b1;
         #1;
         chk_comb($sformatf("wfetch%0d", c), (c == 3) ? 3'b010 : 3'b110, 32'h1000_0040, 32'h0);
         if (c == 3) sb.push_back('{32'h1000_0044, 32'h0123_4567, 32'h0123_4567, 1'b0});
         else        sb.push_back('{32'h1000_0040, 32'h0800_0010, 32'h0800_0010, 1'b0});
         @(posedge Clk);
         #1;
         post_check($sformatf("wfetch%0d", c));
      end

      // Store with 2 wait states; ALUOut/B change after the request cycle
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         drive(7'b0001010, 2'b11, 1'b0, (c == 2), 32'h0,
               (c == 0) ? 32'h100 : 32'h999, (c == 0) ? 32'hDEAD_BEEF : 32'h0, 32'h7777_7777);
         #1;
         chk_comb($sformatf("store%0d", c), (c == 2) ? 3'b001 : 3'b101, 32'h100, 32'hDEAD_BEEF);
         sb.push_back('{32'h1000_0044, 32'h0123_4567, 32'h0123_4567, 1'b0});
         @(posedge Clk);
         #1;
         post_check($sformatf("store%0d", c));
      end

      // Reset asserted while a fetch waits; late mem_ready must not load anything
      @(negedge Clk);
      drive(7'b1000001, 2'b00, 1'b0, 1'b0, 32'h1000_0048, 32'h0, 32'h0, 32'h1111_1111);
      #1;
      chk_comb("rstwait req", 3'b110, 32'h1000_0044, 32'h0);
      @(posedge Clk);
      #1;
      chk1("rstwait in wait", Stall, 1'b1);
      #1;
      Reset = 1'b1;
      #1;
      chk32("rstwait PC", PC, 32'h0);
      chk32("rstwait IR", IR, 32'h0);
      chk32("rstwait MDR", MDR, 32'h0);
      drive(7'b0000000, 2'b11, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
      #1;
      chk_comb("rstwait idle", 3'b000, 32'h0, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk_comb("rstwait late ready", 3'b000, 32'h0, 32'h0);
      sb.push_back('{32'h0, 32'h0, 32'h0, 1'b0});
      @(posedge Clk);
      #1;
      post_check("rstwait after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have Clk  in  1  system clock, rising edge.
REQ-002 SHALL have Reset  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have control inputs from the control unit: PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite (in, 1 each), and PCSource (in, 2).
REQ-004 SHALL have datapath inputs ALUResult, ALUOut and B (in, 32 each), and Zero (in, 1).
REQ-005 SHALL have memory port mem_addr (out, 32), mem_wdata (out, 32), mem_re (out, 1), mem_we (out, 1), mem_rdata (in, 32) and mem_ready (in, 1; access completes this cycle).
REQ-006 SHALL have outputs PC, IR and MDR (out, 32 each).
REQ-007 SHALL have decoded field outputs Op[5:0]=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], shamt=IR[10:6], funct=IR[5:0] and imm16=IR[15:0].
REQ-008 SHALL have outputs Stall (1; control unit holds its state and outputs while high) and AlignErr (1; single-cycle pulse).

Function
REQ-009 SHALL define an access request as IRWrite|MemRead|MemWrite in IDLE; a write request (MemWrite) SHALL take priority over a simultaneous read.
REQ-010 SHALL drive mem_addr = IorD ? ALUOut : PC, mem_wdata = B, mem_re = read request and mem_we = write request, combinationally, in IDLE.
REQ-011 SHALL implement FSM states IDLE, WAIT_RD and WAIT_WR.
REQ-012 SHALL transition IDLE->WAIT_RD on a read request with mem_ready=0, IDLE->WAIT_WR on a write request with mem_ready=0, and WAIT_*->IDLE on mem_ready=1.
REQ-013 SHALL, in WAIT_*, drive the address, data and type latched on IDLE exit, ignoring input changes.
REQ-014 SHALL drive Stall = access active & ~mem_ready, combinationally; zero-wait accesses (mem_ready=1 in the request cycle) SHALL complete in 1 cycle with Stall=0.
REQ-015 SHALL gate all architectural updates (PC, IR, MDR) with ~Stall.
REQ-016 SHALL, on read completion, load MDR<=mem_rdata, and additionally load IR<=mem_rdata if IRWrite is asserted.
REQ-017 SHALL compute pc_we = (PCWrite | (PCWriteCond & (Zero ^ BranchNe))) & ~Stall.
REQ-018 SHALL select the next PC by PCSource: 00 -> ALUResult; 01 -> ALUOut; 10 -> {PC[31:28], IR[25:0], 2'b00}; 11 -> no write (PC holds).
REQ-019 SHALL, if pc_we=1 and the next-PC bits [1:0] != 0, leave PC unchanged and pulse AlignErr for 1 cycle.
REQ-020 SHALL make the fetch cycle (PCWrite=1, IRWrite=1, PCSource=00) load IR from the old-PC address and PC<=ALUResult at the same completing edge.
REQ-021 SHALL perform no memory access, and leave IR/MDR unchanged, when no request is present.

Reset
REQ-022 SHALL, on Reset, immediately set state=IDLE, PC=32'h0000_0000, IR=0, MDR=0, AlignErr=0 and latched access registers=0, with Stall=0 and mem_re=mem_we=0 absent a request.
REQ-023 SHALL, on Reset asserted during WAIT_*, abandon the pending access without any PC/IR/MDR update; a late mem_ready SHALL be ignored.

Structure
REQ-024 SHALL take the PCSource encoding (enum pc_src_t: PCS_ALU, PCS_ALUOUT, PCS_JUMP, PCS_HOLD), the reset vector and the FSM state typedef from the shared package mips_pkg.
REQ-025 SHALL place the next-PC selection and alignment check in one sub-module, pc_sel; the FSM, registers and memory port remain in pc_ir_unit.

Verification
REQ-026 SHALL verify zero-wait fetch: PC=0, mem_rdata=32'h0000_0020 with mem_ready=1, fetch controls, ALUResult=4 -> IR=32'h0000_0020, Op=0, funct=6'h20, PC=4, and Stall never high.
REQ-027 SHALL verify wait-state fetch: mem_ready low for 3 cycles -> Stall high for 3 cycles, PC and IR unchanged during them, and an update on the 4th edge.
REQ-028 SHALL verify BEQ/BNE: PCWriteCond=1, PCSource=01, ALUOut=32'h40 -> with Zero=1/BranchNe=0, PC=32'h40; with Zero=1/BranchNe=1, PC unchanged.
REQ-029 SHALL verify jump: PC=32'h1000_0008, IR[25:0]=26'h10, PCSource=10, PCWrite=1 -> PC=32'h1000_0040.
REQ-030 SHALL verify store with 2 wait states: MemWrite, IorD=1, ALUOut=32'h100, B=32'hDEAD_BEEF -> mem_we held with mem_addr=32'h100 stable for 3 cycles, and MDR unchanged.
REQ-031 SHALL verify misaligned PC write and reset mid-wait: ALUResult=32'h6 with PCWrite=1 -> PC holds and AlignErr pulses for 1 cycle; Reset asserted in WAIT_RD -> PC=0, state=IDLE, and no IR load.
